// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, writes
// little-endian 32-bit words into instruction memory, then releases the core.
//
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
// rx_ready depends only on the current state and never on rx_valid, and
// rx_valid may drop between bytes at any time without side effects.
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [2:0]        state_dbg
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_LEN0  = 3'd0,
        S_LEN1  = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        len_lo;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   word_idx;
    logic [ADDR_W:0]   word_idx_inc;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_buf;
    logic [7:0]        xor_acc;
    logic [15:0]       len_in;
    logic              accept;

    assign len_in       = {rx_data, len_lo};
    assign word_idx_inc = word_idx + {{ADDR_W{1'b0}}, 1'b1};
    assign accept       = rx_valid && rx_ready;

    assign core_reset = (state != S_DONE);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_LEN0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        case (state)
            S_LEN0: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    state_nxt = S_LEN1;
                end
            end
            S_LEN1: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if ({1'b0, len_in} > MAX_WORDS) begin
                        state_nxt = S_ERROR;
                    end else if (len_in == 16'd0) begin
                        state_nxt = S_CSUM;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid && (byte_cnt == 2'd3) && (word_idx_inc == n_words)) begin
                    state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    state_nxt = (rx_data == xor_acc) ? S_DONE : S_ERROR;
                end
            end
            default: begin
                rx_ready = 1'b0;
            end
        endcase
        // Restart wins over any byte accepted in the same cycle.
        if (load_req) begin
            state_nxt = S_LEN0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_lo     <= 8'd0;
            n_words    <= '0;
            word_idx   <= '0;
            byte_cnt   <= 2'd0;
            word_buf   <= 24'd0;
            xor_acc    <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (load_req) begin
                word_idx <= '0;
                byte_cnt <= 2'd0;
                word_buf <= 24'd0;
                xor_acc  <= 8'd0;
            end else if (accept) begin
                if (state != S_CSUM) begin
                    xor_acc <= xor_acc ^ rx_data;
                end
                case (state)
                    S_LEN0: len_lo <= rx_data;
                    S_LEN1: n_words <= len_in[ADDR_W:0];
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_idx[ADDR_W-1:0];
                                imem_wdata <= {rx_data, word_buf};
                                word_idx   <= word_idx_inc;
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: each scenario task drives a byte stream and
// checks status outputs; a negedge scoreboard checks every memory write.
module tb_imem_loader;

  localparam int ADDR_W = 6;

  logic              clk;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              load_req;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;
  logic [2:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] exp_w;
  logic [7:0]         stream_q[$];
  logic [ADDR_W+38:0] rst_obs;
  logic [ADDR_W+38:0] rst_exp;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .load_req(load_req),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_reset(core_reset),
    .done(done),
    .error(error),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard: every write must match the head of exp_q
  always @(negedge clk) begin
    if (reset === 1'b1 && imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== exp_w) begin
          errors++;
          $display("FAIL wr_data: got addr=%0d data=%h, required addr=%0d data=%h",
                   imem_addr, imem_wdata, exp_w[ADDR_W+31:32], exp_w[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int waited;
    idle($urandom_range(0, gap_max));
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    while (rx_ready !== 1'b1 && waited < 16) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 16) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: byte %h never accepted, rx_ready=%b required 1", b, rx_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int count, input int gap_max);
    for (int i = 0; i < count; i++) send_byte(stream_q[i], gap_max);
  endtask

  task automatic pulse_load_req(input logic with_byte);
    load_req = 1'b1;
    rx_valid = with_byte;
    rx_data  = 8'hFF;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic set_good_stream(input logic [7:0] last);
    stream_q = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h02, 8'h20, 8'h54, 8'h00, 8'h02, 8'hAC, last};
  endtask

  task automatic push_good_writes();
    exp_q.push_back({6'd0, 32'h20020005});
    exp_q.push_back({6'd1, 32'hAC020054});
  endtask

  // scenarios
  task automatic test_reset();
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    load_req = 1'b0;
    #12;
    rst_exp = {1'b1, 1'b0, {ADDR_W{1'b0}}, 32'd0, 1'b1, 1'b0, 1'b0, 3'd0};
    rst_obs = {rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error, state_dbg};
    checks++;
    if (rst_obs !== rst_exp) begin
      errors++;
      $display("FAIL reset_values: got %h required %h", rst_obs, rst_exp);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);
    checks++;
    if (state_dbg !== 3'd0 || rx_ready !== 1'b1 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: state=%0d rx_ready=%b core_reset=%b required 0/1/1",
               state_dbg, rx_ready, core_reset);
    end
  endtask

  task automatic test_good_load(input int gap_max);
    pulse_load_req(1'b0);
    push_good_writes();
    set_good_stream(8'hDF);
    send_stream(10, gap_max);
    idle(2);
    checks++;
    if (core_reset !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL good_pre_csum: core_reset=%b done=%b required 1/0", core_reset, done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL good_writes_before_csum: %0d writes missing, required 0", exp_q.size());
    end
    send_byte(8'hDF, gap_max);
    checks++;
    if (done !== 1'b1 || core_reset !== 1'b0 || error !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL good_done: done=%b core_reset=%b error=%b rx_ready=%b required 1/0/0/0",
               done, core_reset, error, rx_ready);
    end
    idle(2);
  endtask

  task automatic test_bad_csum();
    pulse_load_req(1'b0);
    push_good_writes();
    set_good_stream(8'hDE);
    send_stream(11, 0);
    checks++;
    if (error !== 1'b1 || core_reset !== 1'b1 || rx_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum: error=%b core_reset=%b rx_ready=%b done=%b required 1/1/0/0",
               error, core_reset, rx_ready, done);
    end
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_csum_writes: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_empty();
    pulse_load_req(1'b0);
    stream_q = '{8'h00, 8'h00, 8'h00};
    send_stream(3, 0);
    checks++;
    if (done !== 1'b1 || core_reset !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: done=%b core_reset=%b error=%b required 1/0/0", done, core_reset, error);
    end
    idle(3);
  endtask

  task automatic test_oversize();
    pulse_load_req(1'b0);
    stream_q = '{8'h41, 8'h00};
    send_stream(2, 0);
    checks++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL oversize_error: error=%b rx_ready=%b core_reset=%b required 1/0/1",
               error, rx_ready, core_reset);
    end
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || state_dbg !== 3'd5) begin
      errors++;
      $display("FAIL oversize_hold: error=%b rx_ready=%b state=%0d required 1/0/5",
               error, rx_ready, state_dbg);
    end
  endtask

  task automatic test_max_len();
    pulse_load_req(1'b0);
    stream_q = '{8'h40, 8'h00};
    send_stream(2, 0);
    checks++;
    if (state_dbg !== 3'd2 || error !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL max_len_legal: state=%0d error=%b rx_ready=%b required 2/0/1",
               state_dbg, error, rx_ready);
    end
  endtask

  task automatic test_restart();
    pulse_load_req(1'b0);
    exp_q.push_back({6'd0, 32'h20020005});
    set_good_stream(8'hDF);
    send_stream(6, 0);
    idle(1);
    pulse_load_req(1'b1);
    checks++;
    if (state_dbg !== 3'd0 || rx_ready !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_len0: state=%0d rx_ready=%b pending=%0d required 0/1/0",
               state_dbg, rx_ready, exp_q.size());
    end
    push_good_writes();
    send_stream(11, 0);
    checks++;
    if (done !== 1'b1 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL restart_done: done=%b core_reset=%b required 1/0", done, core_reset);
    end
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_writes: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    pulse_load_req(1'b0);
    exp_q.push_back({6'd0, 32'h20020005});
    set_good_stream(8'hDF);
    send_stream(7, 0);
    #2;
    reset = 1'b0;
    #1;
    rst_exp = {1'b1, 1'b0, {ADDR_W{1'b0}}, 32'd0, 1'b1, 1'b0, 1'b0, 3'd0};
    rst_obs = {rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error, state_dbg};
    checks++;
    if (rst_obs !== rst_exp) begin
      errors++;
      $display("FAIL async_reset_values: got %h required %h", rst_obs, rst_exp);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(3);
    checks++;
    if (exp_q.size() != 0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL async_reset_after: pending=%0d state=%0d required 0/0", exp_q.size(), state_dbg);
    end
    test_good_load(0);
  endtask

  task automatic test_backpressure();
    test_good_load(3);
  endtask

  initial begin
    test_reset();
    test_good_load(0);
    test_bad_csum();
    test_empty();
    test_oversize();
    test_max_len();
    test_restart();
    test_backpressure();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_writes: %0d writes missing, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader sitting directly upstream of the single-cycle MIPS core and its instruction memory. It receives a program as a byte stream over a valid/ready link, assembles little-endian 32-bit words, and writes them into instruction memory. It verifies a length header and an XOR checksum, then releases the core from reset. While loading, and after any load error, it holds the core in reset.

## Interface
- `ADDR_W`, default 6: instruction-memory word-address width; capacity `MAX_WORDS = 2**ADDR_W`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte; transfer occurs on an edge where `rx_valid && rx_ready`.
- `load_req`  in  1  single-cycle pulse that restarts a load from any state.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  word data.
- `core_reset`  out  1  active-high reset to the core (`mips.reset`).
- `done`  out  1  load completed with a good checksum.
- `error`  out  1  load failed (bad length or checksum).

## Operation
- Stream format: `LEN_LO`, `LEN_HI` (word count N, 16 bits), then 4·N data bytes, then one `CSUM` byte. `CSUM` is the XOR of every preceding byte, including the length bytes.
- States:
  - `LEN0`: accept byte → `LEN1`.
  - `LEN1`: accept byte; if N > `MAX_WORDS` → `ERROR`; else if N = 0 → `CSUM`; else → `DATA`.
  - `DATA`: accept bytes. A 2-bit byte counter places byte k in bits [8k+7:8k]. On the 4th byte, the word is written and the word index increments. After word N → `CSUM`.
  - `CSUM`: accept byte; if it equals the running XOR → `DONE`, else → `ERROR`.
  - `DONE`: terminal until `load_req`.
  - `ERROR`: terminal until `load_req`.
- `rx_ready` = 1 in `LEN0`, `LEN1`, `DATA`, `CSUM`; 0 in `DONE`, `ERROR`.
- Running XOR and word index clear when entering `LEN0`.
- Word index is ADDR_W+1 bits wide, so N = `MAX_WORDS` is legal. `imem_addr` is the index truncated to ADDR_W bits.
- `core_reset` = 1 in every state except `DONE`. `done` = 1 only in `DONE`. `error` = 1 only in `ERROR`.
- `load_req` has priority over everything. On the next edge the state becomes `LEN0`, with the partial word, XOR and index discarded. A byte handshaked in that same cycle is consumed and dropped.

## Timing
- Reset (async, `reset`=0) values:
  - state `LEN0`, `rx_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_reset`=1, `done`=0, `error`=0.
  - All counters and the XOR are 0.
- `imem_we`, `imem_addr` and `imem_wdata` are registered. The write strobe is high for exactly the cycle after the edge that accepted the word's 4th byte; `imem_addr` and `imem_wdata` are held stable in that cycle.
- Idle cycles (`rx_valid`=0) between bytes are allowed anywhere and change nothing.
- After `CSUM` is accepted, `done`=1 and `core_reset`=0 from the next cycle. The core fetches `pc`=0 on the following rising edge.
- The last data word's write precedes `core_reset` deassertion by at least one cycle, because the `CSUM` byte comes after it.
- Reset asserted mid-load forces the reset values immediately. No further `imem_we` is issued; previously written words stay in memory.
- Throughput: one byte per cycle, no bubbles.

## Test plan
- **Good load, 2 words:** stream `02 00 05 00 02 20 54 00 02 AC DF`, `rx_valid` held high.
  - Writes addr 0 = 0x20020005, then addr 1 = 0xAC020054.
  - `done`=1 and `core_reset`=0 one cycle after `DF` is accepted.
- **Bad checksum:** same stream with last byte `DE`.
  - Both writes occur; `error`=1, `core_reset` stays 1, `rx_ready`=0.
- **Empty program:** stream `00 00 00`.
  - No `imem_we`; `done`=1.
- **Oversized length:** `41 00` with `ADDR_W`=6.
  - `ERROR` one cycle after `41 00`; no writes; subsequent bytes are not accepted.
- **Restart:** `load_req` pulse after 6 bytes of the good stream, then the full good stream resent.
  - Only the two correct writes from the resend at addr 0/1 (addr 0 also written once by the aborted load).
  - `done`=1 at the end.
- **Backpressure gaps and async reset:** insert random `rx_valid`=0 gaps.
  - Results identical to the gap-free run.
  - Assert `reset`=0 mid-`DATA`: outputs take their reset values immediately; a full stream afterwards completes normally.
